// File: rtl/tick_period_monitor.sv
// tick_period_monitor: measures the clock-cycle spacing between rising edges of
// a slow tick strobe, checks each period against EXPECTED +/- TOL, tracks lock
// after LOCK_COUNT consecutive good periods and counts errors (saturating).
module tick_period_monitor #(
    parameter int unsigned N          = 17,
    parameter int unsigned EXPECTED   = 100000,
    parameter int unsigned TOL        = 2,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         tick_in,
    output logic [N-1:0] period,
    output logic         period_valid,
    output logic         in_window,
    output logic         too_short,
    output logic         too_long,
    output logic         locked,
    output logic [7:0]   err_count
);

    localparam int unsigned W = N + 1;
    // Bounds are one bit wider than the counter so EXPECTED+TOL cannot wrap.
    localparam logic [W-1:0] LO_BOUND    = (EXPECTED >= TOL) ? W'(EXPECTED - TOL) : W'(0);
    localparam logic [W-1:0] HI_BOUND    = W'(EXPECTED + TOL);
    localparam logic [N-1:0] CNT_MAX     = {N{1'b1}};
    localparam logic [3:0]   LOCK_TARGET = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    state_t       state, state_next;
    logic         tick_d;
    logic [N-1:0] cnt, cnt_next;
    logic [3:0]   good_run, good_run_next;
    logic [N-1:0] period_next;
    logic         period_valid_next;
    logic         in_window_next;
    logic         too_short_next;
    logic         too_long_next;
    logic         locked_next;
    logic [7:0]   err_count_next;
    logic         err_event;
    logic         tick_edge;
    logic [W-1:0] cnt_ext;

    assign tick_edge = tick_in & ~tick_d;
    assign cnt_ext   = {1'b0, cnt};

    // Next-state and next-output logic for the measurement FSM.
    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        good_run_next     = good_run;
        period_next       = period;
        period_valid_next = 1'b0;
        in_window_next    = in_window;
        too_short_next    = too_short;
        too_long_next     = too_long;
        locked_next       = locked;
        err_count_next    = err_count;
        err_event         = 1'b0;

        case (state)
            IDLE: begin
                if (tick_edge) begin
                    state_next = MEASURE;
                    cnt_next   = N'(1);
                end
            end
            MEASURE: begin
                if (tick_edge) begin
                    cnt_next          = N'(1);
                    period_next       = cnt;
                    period_valid_next = 1'b1;
                    if ((cnt_ext >= LO_BOUND) && (cnt_ext <= HI_BOUND)) begin
                        in_window_next = 1'b1;
                        too_short_next = 1'b0;
                        too_long_next  = 1'b0;
                        if (good_run < LOCK_TARGET) begin
                            good_run_next = good_run + 4'd1;
                        end
                        if (good_run_next == LOCK_TARGET) begin
                            locked_next = 1'b1;
                        end
                    end else begin
                        in_window_next = 1'b0;
                        too_short_next = (cnt_ext < LO_BOUND);
                        too_long_next  = (cnt_ext > HI_BOUND);
                        good_run_next  = 4'd0;
                        locked_next    = 1'b0;
                        err_event      = 1'b1;
                    end
                end else if (cnt == CNT_MAX) begin
                    // Flags are reported on entry so they appear one cycle after cnt saturates.
                    state_next     = TIMEOUT;
                    too_long_next  = 1'b1;
                    too_short_next = 1'b0;
                    in_window_next = 1'b0;
                    good_run_next  = 4'd0;
                    locked_next    = 1'b0;
                    err_event      = 1'b1;
                end else begin
                    cnt_next = cnt + N'(1);
                end
            end
            TIMEOUT: begin
                // Any edge seen here is deliberately dropped; the next edge restarts from IDLE.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (err_event && (err_count != 8'hFF)) begin
            err_count_next = err_count + 8'd1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            tick_d       <= 1'b0;
            cnt          <= '0;
            good_run     <= 4'd0;
            period       <= '0;
            period_valid <= 1'b0;
            in_window    <= 1'b0;
            too_short    <= 1'b0;
            too_long     <= 1'b0;
            locked       <= 1'b0;
            err_count    <= 8'd0;
        end else begin
            state        <= state_next;
            tick_d       <= tick_in;
            cnt          <= cnt_next;
            good_run     <= good_run_next;
            period       <= period_next;
            period_valid <= period_valid_next;
            in_window    <= in_window_next;
            too_short    <= too_short_next;
            too_long     <= too_long_next;
            locked       <= locked_next;
            err_count    <= err_count_next;
        end
    end

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed self-checking bench for tick_period_monitor (N=5, EXPECTED=10, TOL=1, LOCK_COUNT=3).
module tb_tick_period_monitor;

    localparam int unsigned N = 5;

    logic         clock;
    logic         reset;
    logic         tick_in;
    logic [N-1:0] period;
    logic         period_valid;
    logic         in_window;
    logic         too_short;
    logic         too_long;
    logic         locked;
    logic [7:0]   err_count;

    int checks = 0;
    int errors = 0;
    int pv_count = 0;

    tick_period_monitor #(
        .N(5), .EXPECTED(10), .TOL(1), .LOCK_COUNT(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .tick_in(tick_in),
        .period(period),
        .period_valid(period_valid),
        .in_window(in_window),
        .too_short(too_short),
        .too_long(too_long),
        .locked(locked),
        .err_count(err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count every cycle period_valid is high, sampled mid-cycle.
    always @(negedge clock) if (period_valid) pv_count++;

    // Hard stop if the bench ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance to just after the next rising clock edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        tick_in = 1'b0;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Low for p-1 cycles then a one-cycle high: rising edge lands p cycles after the previous one.
    task automatic edge_after(input int p);
        tick_in = 1'b0;
        repeat (p - 1) cyc();
        tick_in = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        int pv0;
        do_reset();
        checks++; if ({period, period_valid, in_window, too_short, too_long, locked, err_count} !== 18'd0)
            begin errors++; $display("FAIL reset_outputs: got %h expected 0", {period, period_valid, in_window, too_short, too_long, locked, err_count}); end
        pv0 = pv_count;
        repeat (40) cyc();
        checks++; if ({period, period_valid, in_window, too_short, too_long, locked, err_count} !== 18'd0)
            begin errors++; $display("FAIL idle_40: got %h expected 0", {period, period_valid, in_window, too_short, too_long, locked, err_count}); end
        checks++; if (pv_count - pv0 !== 0) begin errors++; $display("FAIL idle_pv: got %0d expected 0", pv_count - pv0); end
    endtask

    task automatic test_steady();
        int pv0;
        do_reset();
        pv0 = pv_count;
        tick_in = 1'b1;
        cyc();
        checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL first_edge_pv: got %b expected 0", period_valid); end
        for (int i = 1; i <= 4; i++) begin
            edge_after(10);
            checks++; if (period !== 5'd10) begin errors++; $display("FAIL steady_period%0d: got %0d expected 10", i, period); end
            checks++; if (period_valid !== 1'b1) begin errors++; $display("FAIL steady_pv%0d: got %b expected 1", i, period_valid); end
            checks++; if (in_window !== 1'b1) begin errors++; $display("FAIL steady_win%0d: got %b expected 1", i, in_window); end
            checks++; if (locked !== (i >= 3)) begin errors++; $display("FAIL steady_lock%0d: got %b expected %b", i, locked, (i >= 3)); end
        end
        tick_in = 1'b0;
        cyc();
        checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL pv_one_cycle: got %b expected 0", period_valid); end
        checks++; if (pv_count - pv0 !== 4) begin errors++; $display("FAIL steady_pv_count: got %0d expected 4", pv_count - pv0); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL steady_err: got %0d expected 0", err_count); end
    endtask

    task automatic test_short_relock();
        do_reset();
        tick_in = 1'b1;
        cyc();
        repeat (3) edge_after(10);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL pre_short_lock: got %b expected 1", locked); end
        edge_after(7);
        checks++; if (period !== 5'd7) begin errors++; $display("FAIL short_period: got %0d expected 7", period); end
        checks++; if ({too_short, too_long, in_window, locked} !== 4'b1000) begin errors++; $display("FAIL short_flags: got %b expected 1000", {too_short, too_long, in_window, locked}); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL short_err: got %0d expected 1", err_count); end
        edge_after(11);
        checks++; if ({too_short, too_long, in_window, locked} !== 4'b0010) begin errors++; $display("FAIL relock_11: got %b expected 0010", {too_short, too_long, in_window, locked}); end
        edge_after(9);
        checks++; if ({in_window, locked} !== 2'b10) begin errors++; $display("FAIL relock_9: got %b expected 10", {in_window, locked}); end
        edge_after(10);
        checks++; if ({in_window, locked} !== 2'b11) begin errors++; $display("FAIL relock_10: got %b expected 11", {in_window, locked}); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL relock_err: got %0d expected 1", err_count); end
        edge_after(12);
        checks++; if ({too_short, too_long, in_window, locked} !== 4'b0100) begin errors++; $display("FAIL long_flags: got %b expected 0100", {too_short, too_long, in_window, locked}); end
        checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL long_err: got %0d expected 2", err_count); end
    endtask

    task automatic test_timeout();
        do_reset();
        tick_in = 1'b1;
        cyc();
        repeat (3) edge_after(10);
        tick_in = 1'b0;
        repeat (30) cyc();
        checks++; if ({too_long, locked} !== 2'b01) begin errors++; $display("FAIL pre_timeout: got %b expected 01", {too_long, locked}); end
        cyc();
        checks++; if ({too_long, too_short, in_window, locked} !== 4'b1000) begin errors++; $display("FAIL timeout_flags: got %b expected 1000", {too_long, too_short, in_window, locked}); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL timeout_err: got %0d expected 1", err_count); end
        checks++; if (period !== 5'd10) begin errors++; $display("FAIL timeout_period_held: got %0d expected 10", period); end
        repeat (3) cyc();
        tick_in = 1'b1;
        cyc();
        checks++; if ({period_valid, too_long} !== 2'b01) begin errors++; $display("FAIL rearm_edge: got %b expected 01", {period_valid, too_long}); end
        edge_after(10);
        checks++; if ({period_valid, in_window, too_long} !== 3'b110) begin errors++; $display("FAIL resume_flags: got %b expected 110", {period_valid, in_window, too_long}); end
        checks++; if (period !== 5'd10) begin errors++; $display("FAIL resume_period: got %0d expected 10", period); end
    endtask

    task automatic test_wide_pulse();
        int pv0;
        do_reset();
        pv0 = pv_count;
        tick_in = 1'b1;
        repeat (4) cyc();
        tick_in = 1'b0;
        repeat (6) cyc();
        for (int i = 1; i <= 3; i++) begin
            tick_in = 1'b1;
            cyc();
            checks++; if ({period, period_valid} !== {5'd10, 1'b1}) begin errors++; $display("FAIL wide_report%0d: got period %0d pv %b expected 10 1", i, period, period_valid); end
            repeat (3) cyc();
            tick_in = 1'b0;
            repeat (6) cyc();
        end
        checks++; if (pv_count - pv0 !== 3) begin errors++; $display("FAIL wide_pv_count: got %0d expected 3", pv_count - pv0); end
    endtask

    task automatic test_reset_sat();
        do_reset();
        tick_in = 1'b1;
        cyc();
        repeat (3) edge_after(10);
        tick_in = 1'b0;
        repeat (4) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++; if ({period, period_valid, in_window, too_short, too_long, locked, err_count} !== 18'd0)
            begin errors++; $display("FAIL midreset_outputs: got %h expected 0", {period, period_valid, in_window, too_short, too_long, locked, err_count}); end
        tick_in = 1'b1;
        cyc();
        checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL midreset_first_edge: got %b expected 0", period_valid); end
        for (int i = 1; i <= 300; i++) begin
            tick_in = 1'b0;
            cyc();
            tick_in = 1'b1;
            cyc();
            if (i == 1) begin
                checks++; if ({period, too_short} !== {5'd2, 1'b1}) begin errors++; $display("FAIL toggle_period: got %0d short %b expected 2 1", period, too_short); end
            end
            if (i == 254) begin
                checks++; if (err_count !== 8'd254) begin errors++; $display("FAIL err_254: got %0d expected 254", err_count); end
            end
        end
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_saturate: got %0d expected 255", err_count); end
        checks++; if ({too_short, locked} !== 2'b10) begin errors++; $display("FAIL sat_flags: got %b expected 10", {too_short, locked}); end
    endtask

    initial begin
        reset = 1'b1;
        tick_in = 1'b0;
        test_reset();
        test_steady();
        test_short_relock();
        test_timeout();
        test_wide_pulse();
        test_reset_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
